// File: rtl/fp16_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp16_normalize_pack
// Description : Normalises the unnormalised fp_int_mul product
//               {sign, biased exponent, 15-bit fixed-point mantissa} one left
//               shift per cycle, rounds to nearest-even on 10 fraction bits
//               and packs an IEEE FP16 word with overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_normalize_pack #(
    parameter int MANT_WIDTH = 15,
    parameter int FRAC_IN    = 10,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sign_in,
    input  logic [4:0]            exp_in,
    input  logic [MANT_WIDTH-1:0] mantissa_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_WIDTH-1:0]  result,
    output logic                  ovf,
    output logic                  unf
);

    // Bit positions within the normalised mantissa (leading one at the MSB).
    localparam int c_MSB       = MANT_WIDTH - 1;
    localparam int c_FRAC_HI   = MANT_WIDTH - 2;
    localparam int c_GUARD_BIT = MANT_WIDTH - 2 - FRAC_IN;
    localparam int c_STICKY_HI = MANT_WIDTH - 3 - FRAC_IN;

    // A leading one at bit c_MSB weighs 2^(c_MSB-FRAC_IN) relative to 1.0.
    localparam logic signed [6:0] c_EXP_ADJ = 7'(MANT_WIDTH - 1 - FRAC_IN);
    localparam logic signed [6:0] c_EXP_MAX = 7'sd31;
    localparam logic signed [6:0] c_EXP_MIN = 7'sd0;

    localparam logic [15:0] c_QNAN = 16'h7E00;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_NORM  = 2'd1;
    localparam logic [1:0] c_ST_ROUND = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;

    logic [MANT_WIDTH-1:0] r_m;
    logic [4:0]            r_e;
    logic [3:0]            r_k;
    logic                  r_s;

    logic                  r_done;
    logic [OUT_WIDTH-1:0]  r_result;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_norm_done;
    logic [FRAC_IN-1:0]    w_frac;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_round_up;
    logic [FRAC_IN:0]      w_frac_sum;
    logic [FRAC_IN-1:0]    w_frac_rnd;
    logic                  w_carry;
    logic signed [6:0]     w_exp_pre;
    logic signed [6:0]     w_exp_rnd;
    logic [OUT_WIDTH-1:0]  w_result;
    logic                  w_ovf;
    logic                  w_unf;

    assign busy   = (r_state != c_ST_IDLE);
    assign done   = r_done;
    assign result = r_result;
    assign ovf    = r_ovf;
    assign unf    = r_unf;

    // Normalisation stops once the leading one reaches the MSB, or at once
    // for a zero mantissa (which would otherwise never terminate).
    assign w_norm_done = r_m[c_MSB] | (r_m == '0);

    assign w_frac     = r_m[c_FRAC_HI -: FRAC_IN];
    assign w_guard    = r_m[c_GUARD_BIT];
    assign w_sticky   = |r_m[c_STICKY_HI:0];
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {{FRAC_IN{1'b0}}, w_round_up};
    assign w_frac_rnd = w_frac_sum[FRAC_IN-1:0];
    assign w_carry    = w_frac_sum[FRAC_IN];

    // Signed 7-bit exponent: range is about -10..36, so under/overflow are
    // visible as plain signed comparisons.
    assign w_exp_pre = $signed({2'b00, r_e}) + c_EXP_ADJ - $signed({3'b000, r_k});
    assign w_exp_rnd = w_exp_pre + $signed({6'b000000, w_carry});

    // Packs the rounded value, applying the special cases in priority order.
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        if (r_e == 5'd31) begin
            w_result = c_QNAN;
        end else if (r_m == '0) begin
            w_result = {r_s, 15'b0};
        end else if (w_exp_rnd >= c_EXP_MAX) begin
            w_result = {r_s, 5'h1F, 10'h000};
            w_ovf    = 1'b1;
        end else if (w_exp_rnd <= c_EXP_MIN) begin
            w_result = {r_s, 15'b0};
            w_unf    = 1'b1;
        end else begin
            w_result = {r_s, w_exp_rnd[4:0], w_frac_rnd};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> NORM on start, NORM until normalised, one ROUND cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_NORM;
                end
            end
            c_ST_NORM: begin
                if (w_norm_done) begin
                    w_state_next = c_ST_ROUND;
                end
            end
            c_ST_ROUND: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Datapath: capture operands, shift one place per NORM cycle, publish result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m      <= '0;
            r_e      <= '0;
            r_k      <= '0;
            r_s      <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_m <= mantissa_in;
                        r_e <= exp_in;
                        r_s <= sign_in;
                        r_k <= '0;
                    end
                end
                c_ST_NORM: begin
                    if (!w_norm_done) begin
                        r_m <= {r_m[MANT_WIDTH-2:0], 1'b0};
                        r_k <= r_k + 4'd1;
                    end
                end
                c_ST_ROUND: begin
                    r_result <= w_result;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_normalize_pack
// Description : Directed vector bench for fp16_normalize_pack: table of
//               hand-computed conversions plus handshake/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_normalize_pack;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [14:0] mantissa_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic        unf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        s;
        logic [4:0]  e;
        logic [14:0] m;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    fp16_normalize_pack dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sign_in    (sign_in),
        .exp_in     (exp_in),
        .mantissa_in(mantissa_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .ovf        (ovf),
        .unf        (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents operands for exactly one clock edge (the start edge).
    task automatic apply_start(input logic s, input logic [4:0] e, input logic [14:0] m);
        start       = 1'b1;
        sign_in     = s;
        exp_in      = e;
        mantissa_in = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; busy must stay high on every cycle before it.
    task automatic wait_done(output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_bad;
        int pulses;

        vecs.push_back('{"k1_neg",      1'b1, 5'd16, 15'h21F6, 16'hCC3F, 1'b0, 1'b0,  3});
        vecs.push_back('{"normed",      1'b0, 5'd15, 15'h4000, 16'h4C00, 1'b0, 1'b0,  2});
        vecs.push_back('{"zero_neg",    1'b1, 5'd5,  15'h0000, 16'h8000, 1'b0, 1'b0,  2});
        vecs.push_back('{"max_shift",   1'b0, 5'd20, 15'h0001, 16'h2800, 1'b0, 1'b0, 16});
        vecs.push_back('{"tie_carry",   1'b0, 5'd10, 15'h7FF8, 16'h3C00, 1'b0, 1'b0,  2});
        vecs.push_back('{"tie_even_dn", 1'b0, 5'd15, 15'h4008, 16'h4C00, 1'b0, 1'b0,  2});
        vecs.push_back('{"tie_odd_up",  1'b0, 5'd15, 15'h4018, 16'h4C02, 1'b0, 1'b0,  2});
        vecs.push_back('{"ovf_pos",     1'b0, 5'd30, 15'h7FFF, 16'h7C00, 1'b1, 1'b0,  2});
        vecs.push_back('{"ovf_neg",     1'b1, 5'd30, 15'h7FFF, 16'hFC00, 1'b1, 1'b0,  2});
        vecs.push_back('{"exp31_edge",  1'b0, 5'd27, 15'h4000, 16'h7C00, 1'b1, 1'b0,  2});
        vecs.push_back('{"max_normal",  1'b0, 5'd26, 15'h7FE0, 16'h7BFE, 1'b0, 1'b0,  2});
        vecs.push_back('{"rnd_to_ovf",  1'b0, 5'd26, 15'h7FF8, 16'h7C00, 1'b1, 1'b0,  2});
        vecs.push_back('{"unf_min",     1'b0, 5'd0,  15'h0001, 16'h0000, 1'b0, 1'b1, 16});
        vecs.push_back('{"unf_e0",      1'b0, 5'd0,  15'h0400, 16'h0000, 1'b0, 1'b1,  6});
        vecs.push_back('{"min_normal",  1'b0, 5'd1,  15'h0400, 16'h0400, 1'b0, 1'b0,  6});
        vecs.push_back('{"nan",         1'b1, 5'd31, 15'h1234, 16'h7E00, 1'b0, 1'b0,  4});
        vecs.push_back('{"nan_zero",    1'b0, 5'd31, 15'h0000, 16'h7E00, 1'b0, 1'b0,  2});

        rst         = 1'b0;
        start       = 1'b0;
        sign_in     = 1'b0;
        exp_in      = '0;
        mantissa_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'h0000);
        check("rst_flags",  32'({ovf, unf}), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_start(vecs[i].s, vecs[i].e, vecs[i].m);
            wait_done(lat, busy_bad);
            check({vecs[i].name, "_lat"},    32'(lat),      32'(vecs[i].lat));
            check({vecs[i].name, "_res"},    32'(result),   32'(vecs[i].res));
            check({vecs[i].name, "_ovf"},    32'(ovf),      32'(vecs[i].ovf));
            check({vecs[i].name, "_unf"},    32'(unf),      32'(vecs[i].unf));
            check({vecs[i].name, "_busyhi"}, 32'(busy_bad), 32'd0);
            check({vecs[i].name, "_busylo"}, 32'(busy),     32'd0);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_pulse"}, 32'(done), 32'd0);
        end

        // Start re-pulsed mid-conversion with different operands must be ignored.
        apply_start(1'b0, 5'd20, 15'h0001);
        repeat (3) @(posedge clk);
        #1;
        start       = 1'b1;
        sign_in     = 1'b1;
        exp_in      = 5'd15;
        mantissa_in = 15'h4000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, busy_bad);
        check("ignore_lat",  32'(lat + 4), 32'd16);
        check("ignore_res",  32'(result),  32'h2800);
        check("ignore_busy", 32'(busy_bad), 32'd0);

        // Back-to-back: start presented on the done cycle is accepted.
        apply_start(1'b1, 5'd16, 15'h21F6);
        wait_done(lat, busy_bad);
        check("b2b_lat", 32'(lat),    32'd3);
        check("b2b_res", 32'(result), 32'hCC3F);
        @(posedge clk);
        #1;

        // Reset during the fifth NORM cycle aborts without a done pulse.
        apply_start(1'b0, 5'd20, 15'h0001);
        repeat (4) @(posedge clk);
        #1;
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'h0000);
        check("abort_flags",  32'({ovf, unf}), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_idle",    32'(busy),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
